// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the program-image loader.
// Holds the default geometry of the loader RAM and the loader FSM state
// encoding, so the top level and any bench see one definition.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;   // word address width (256 words)
    localparam int DATA_W_DEF = 16;  // word width

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,  // waiting for the high byte of a word
        LOAD_LO = 2'd1,  // high byte held, waiting for the low byte
        RUN     = 2'd2   // image loaded, CPU owns the RAM port
    } ld_state_e;

endpackage

// File: rtl/sp_ram.sv
// sp_ram -- single-port synchronous RAM, read-first, no reset.
// Ports:
//   clk_i    clock
//   we_i     write enable (write takes effect at the rising edge)
//   addr_i   word address for both read and write
//   wdata_i  write data
//   rdata_o  registered read data: mem[addr_i] as it was before the edge
// Kept free of any reset so the array maps onto block RAM.
module sp_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Read and write in the same process: the read samples the old word,
    // giving read-first behaviour on a same-address collision.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[addr_i];
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_loader.sv
// mem_loader -- loads a byte-serial program image into a word RAM, then
// hands the RAM port to the CPU and releases it from reset.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_addr/cpu_wdata/cpu_we  CPU RAM access (honoured only in RUN)
//   cpu_rdata                1-cycle-latency read data, 0 outside RUN
//   ld_valid/ld_byte/ld_last byte stream in, high byte first per word
//   ld_ready                 a byte is accepted this cycle
//   cpu_run                  image loaded; CPU may run
//   load_err                 sticky: image was larger than the RAM
module mem_loader
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_run,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_q, err_d;
    logic              run_q;
    logic              rd_valid_q;

    logic              load_we;
    logic [DATA_W-1:0] load_wdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD_HI;
            addr_q     <= '0;
            hi_q       <= '0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            err_q      <= err_d;
            run_q      <= (state_d == RUN);
            // Read data is only exposed for reads issued while in RUN.
            rd_valid_q <= (state_q == RUN);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        err_d      = err_q;
        ld_ready   = 1'b0;
        load_we    = 1'b0;
        load_wdata = '0;
        case (state_q)
            LOAD_HI: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    hi_d = ld_byte;
                    if (ld_last) begin
                        // Odd-length image: pad the final word's low byte.
                        load_we    = 1'b1;
                        load_wdata = DATA_W'({ld_byte, 8'h00});
                        state_d    = RUN;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    load_we    = 1'b1;
                    load_wdata = DATA_W'({hi_q, ld_byte});
                    // Address saturates at the top word; never wraps.
                    if (addr_q != ADDR_MAX) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (ld_last) begin
                        state_d = RUN;
                    end else if (addr_q == ADDR_MAX) begin
                        state_d = RUN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            RUN: begin
                // Terminal until reset; byte stream is ignored.
            end
            default: state_d = LOAD_HI;
        endcase
    end

    // RAM port ownership: loader while loading, CPU once running.
    always_comb begin
        if (state_q == RUN) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else begin
            ram_we    = load_we;
            ram_addr  = addr_q;
            ram_wdata = load_wdata;
        end
    end

    sp_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign cpu_rdata = rd_valid_q ? ram_rdata : '0;
    assign cpu_run   = run_q;
    assign load_err  = err_q;

endmodule
